// File: rtl/nonogram_pkg.sv
// Shared nonogram constants, header layout, parser states and frame arithmetic.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package nonogram_pkg;

    localparam int MAX_ROWS  = 11;
    localparam int MAX_COLS  = 11;
    localparam int DIM_W     = 4;
    localparam int MAX_CELLS = MAX_ROWS * MAX_COLS;
    localparam int CELL_W    = 7;
    localparam int MAX_BYTES = 16;
    localparam int BCNT_W    = 5;

    typedef struct packed {
        logic [DIM_W-1:0] m;
        logic [DIM_W-1:0] n;
    } hdr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Widen before multiplying so the 4x4 product is not truncated.
    function automatic logic [CELL_W-1:0] cell_count(input hdr_t h);
        return CELL_W'(h.m) * CELL_W'(h.n);
    endfunction

    function automatic logic [BCNT_W-1:0] byte_count(input logic [CELL_W-1:0] cells);
        logic [CELL_W:0] t;
        t = {1'b0, cells} + (CELL_W+1)'(7);
        return t[CELL_W:3];
    endfunction

endpackage

// File: rtl/solution_unpacker_idle_timer.sv
// Idle timer: counts enabled cycles, flags expiry on the TIMEOUT_CYCLES-th one.
// Latency: expired is combinational from the count and en/clr.
// Backpressure: none; clr has priority over en.
module idle_timer #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk_50mhz,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/solution_unpacker.sv
// Rebuilds the m x n solution bitmap from the header/data(/checksum) byte stream.
// Latency: done/error one cycle after the terminating strobe; one byte per cycle.
// Backpressure: none, every strobe is consumed. Optional checksum: SOLUTION_CHECKSUM_EN.
module solution_unpacker #(
    parameter int MAX_ROWS       = 11,
    parameter int MAX_COLS       = 11,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                         clk_50mhz,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic [7:0]                   byte_in,
    output logic [MAX_ROWS*MAX_COLS-1:0] solution,
    output logic [3:0]                   m,
    output logic [3:0]                   n,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);

    import nonogram_pkg::*;

    localparam int SOL_W = MAX_ROWS * MAX_COLS;

    state_t              state_q, state_d;
    logic [SOL_W-1:0]    sol_q, sol_d;
    logic [DIM_W-1:0]    m_q, m_d, n_q, n_d;
    logic [CELL_W-1:0]   cells_q, cells_d;
    logic [BCNT_W-1:0]   cnt_q, cnt_d;
    logic [BCNT_W-1:0]   last_q, last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    hdr_t hdr;
    logic hdr_ok;
    logic tmr_clr, tmr_en, tmr_expired;

`ifdef SOLUTION_CHECKSUM_EN
    logic [7:0] xor_q, xor_d;
`endif

    assign hdr    = hdr_t'(byte_in);
    assign hdr_ok = (hdr.m != '0) && (hdr.m <= DIM_W'(MAX_ROWS)) &&
                    (hdr.n != '0) && (hdr.n <= DIM_W'(MAX_COLS));

    // Timer restarts on every strobe and stays cleared outside a frame.
    assign tmr_clr = (state_q == IDLE) || valid_in;
    assign tmr_en  = !tmr_clr;

    idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk_50mhz(clk_50mhz),
        .rst      (rst),
        .clr      (tmr_clr),
        .en       (tmr_en),
        .expired  (tmr_expired)
    );

    always_comb begin
        state_d = state_q;
        sol_d   = sol_q;
        m_d     = m_q;
        n_d     = n_q;
        cells_d = cells_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        done_d  = 1'b0;
        error_d = 1'b0;
`ifdef SOLUTION_CHECKSUM_EN
        xor_d   = xor_q;
`endif

        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (hdr_ok) begin
                        m_d     = hdr.m;
                        n_d     = hdr.n;
                        cells_d = cell_count(hdr);
                        last_d  = byte_count(cell_count(hdr)) - BCNT_W'(1);
                        sol_d   = '0;
                        cnt_d   = '0;
                        state_d = DATA;
`ifdef SOLUTION_CHECKSUM_EN
                        xor_d   = byte_in;
`endif
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end

            DATA: begin
                if (valid_in) begin
                    // Only cells of the current byte that lie inside m*n are written.
                    for (int i = 0; i < SOL_W; i++) begin
                        if ((BCNT_W'(i >> 3) == cnt_q) && (CELL_W'(i) < cells_q)) begin
                            sol_d[i] = byte_in[3'(i % 8)];
                        end
                    end
`ifdef SOLUTION_CHECKSUM_EN
                    xor_d = xor_q ^ byte_in;
`endif
                    if (cnt_q == last_q) begin
`ifdef SOLUTION_CHECKSUM_EN
                        state_d = CHECK;
`else
                        done_d  = 1'b1;
                        state_d = IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q + BCNT_W'(1);
                    end
                end else if (tmr_expired) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end

`ifdef SOLUTION_CHECKSUM_EN
            CHECK: begin
                if (valid_in) begin
                    if (byte_in == xor_q) begin
                        done_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                    state_d = IDLE;
                end else if (tmr_expired) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            state_q <= IDLE;
            sol_q   <= '0;
            m_q     <= '0;
            n_q     <= '0;
            cells_q <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef SOLUTION_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sol_q   <= sol_d;
            m_q     <= m_d;
            n_q     <= n_d;
            cells_q <= cells_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
`ifdef SOLUTION_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    assign solution = sol_q;
    assign m        = m_q;
    assign n        = n_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_solution_unpacker.sv
// Bench for solution_unpacker: fixed vector table, randomized frames against a
// frame-level reference decoder, plus timeout and mid-frame reset sequences.
module tb_solution_unpacker;

`ifdef SOLUTION_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    localparam int TMO = 100;

    logic         clk_50mhz = 1'b0;
    logic         rst = 1'b1;
    logic         valid_in = 1'b0;
    logic [7:0]   byte_in = 8'h00;
    logic [120:0] solution;
    logic [3:0]   m, n;
    logic         busy, done, error;

    int checks = 0;
    int errors = 0;
    int ndone = 0;
    int nerr = 0;

    solution_unpacker #(
        .MAX_ROWS(11),
        .MAX_COLS(11),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_50mhz(clk_50mhz),
        .rst      (rst),
        .valid_in (valid_in),
        .byte_in  (byte_in),
        .solution (solution),
        .m        (m),
        .n        (n),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    always @(posedge clk_50mhz) begin
        #1;
        if (done)  ndone++;
        if (error) nerr++;
    end

    typedef struct {
        int           len;
        logic [159:0] bytes;     // first byte is the most significant of len bytes
        bit           exp_done;
        bit           exp_err;
        int           exp_ne;
        logic [120:0] exp_sol;
        logic [3:0]   exp_m;
        logic [3:0]   exp_n;
    } vec_t;

    function automatic vec_t mk(input int len, input logic [159:0] b, input bit d, input bit e,
                                input int ne, input logic [120:0] s, input logic [3:0] mm,
                                input logic [3:0] nn);
        vec_t v;
        v.len = len; v.bytes = b; v.exp_done = d; v.exp_err = e; v.exp_ne = ne;
        v.exp_sol = s; v.exp_m = mm; v.exp_n = nn;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] q[$], input int gap);
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk_50mhz);
            valid_in = 1'b1;
            byte_in  = q[i];
            if (i != q.size() - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk_50mhz);
                    valid_in = 1'b0;
                end
            end
        end
        @(negedge clk_50mhz);
        valid_in = 1'b0;
        byte_in  = 8'h00;
    endtask

    // Reference decoder: works on a whole frame from the format rules.
    logic [120:0] rm_sol;
    logic [3:0]   rm_m, rm_n;
    bit           rm_done, rm_err;

    task automatic ref_frame(input logic [7:0] q[$]);
        int mm, nn, cells;
        logic [7:0] x, b;
        mm = int'(q[0][7:4]);
        nn = int'(q[0][3:0]);
        if (mm < 1 || mm > 11 || nn < 1 || nn > 11) begin
            rm_done = 0; rm_err = 1;
            return;
        end
        rm_m = q[0][7:4];
        rm_n = q[0][3:0];
        cells = mm * nn;
        rm_sol = '0;
        for (int r = 0; r < mm; r++) begin
            for (int c = 0; c < nn; c++) begin
                b = q[1 + (r * nn + c) / 8];
                rm_sol[r * nn + c] = b[(r * nn + c) % 8];
            end
        end
        if (CK) begin
            x = 8'h00;
            for (int i = 0; i < q.size() - 1; i++) x ^= q[i];
            rm_done = (x == q[q.size() - 1]);
            rm_err  = !rm_done;
        end else begin
            rm_done = 1; rm_err = 0;
        end
    endtask

    vec_t v[11];
    logic [7:0] q[$];

    initial begin
        int d0, e0, cyc;

        v[0]  = CK ? mk(3, {8'h23, 8'h2D, 8'h0E}, 1, 0, 0, 121'h2D, 2, 3)
                   : mk(2, {8'h23, 8'h2D}, 1, 0, 0, 121'h2D, 2, 3);
        v[1]  = CK ? mk(18, {8'hBB, {16{8'hFF}}, 8'hBB}, 1, 0, 0, {121{1'b1}}, 11, 11)
                   : mk(17, {8'hBB, {16{8'hFF}}}, 1, 0, 0, {121{1'b1}}, 11, 11);
        v[2]  = CK ? mk(4, {8'h33, 8'hFF, 8'hFF, 8'h33}, 1, 0, 0, 121'h1FF, 3, 3)
                   : mk(3, {8'h33, 8'hFF, 8'hFF}, 1, 0, 0, 121'h1FF, 3, 3);
        v[3]  = mk(1, {8'hC3}, 0, 1, 1, 121'h1FF, 3, 3);
        v[4]  = mk(1, {8'h20}, 0, 1, 1, 121'h1FF, 3, 3);
        v[5]  = CK ? mk(4, {8'hC3, 8'h23, 8'h2D, 8'h0E}, 1, 0, 1, 121'h2D, 2, 3)
                   : mk(3, {8'hC3, 8'h23, 8'h2D}, 1, 0, 1, 121'h2D, 2, 3);
        v[6]  = CK ? mk(3, {8'h18, 8'hA5, 8'hBD}, 1, 0, 0, 121'hA5, 1, 8)
                   : mk(2, {8'h18, 8'hA5}, 1, 0, 0, 121'hA5, 1, 8);
        v[7]  = CK ? mk(4, {8'h19, 8'h00, 8'hFF, 8'hE6}, 1, 0, 0, 121'h100, 1, 9)
                   : mk(3, {8'h19, 8'h00, 8'hFF}, 1, 0, 0, 121'h100, 1, 9);
        v[8]  = CK ? mk(3, {8'h23, 8'h2D, 8'h0F}, 0, 1, 1, 121'h2D, 2, 3)
                   : mk(2, {8'h23, 8'h2D}, 1, 0, 0, 121'h2D, 2, 3);
        v[9]  = CK ? mk(3, {8'h22, 8'h0A, 8'h28}, 1, 0, 0, 121'hA, 2, 2)
                   : mk(2, {8'h22, 8'h0A}, 1, 0, 0, 121'hA, 2, 2);
        v[10] = CK ? mk(3, {8'h11, 8'h01, 8'h10}, 1, 0, 0, 121'h1, 1, 1)
                   : mk(2, {8'h11, 8'h01}, 1, 0, 0, 121'h1, 1, 1);

        // Reset state
        repeat (3) @(negedge clk_50mhz);
        chk("rst_sol", solution, 0);
        chk("rst_m", m, 0);
        chk("rst_n", n, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        rst = 1'b0;
        @(negedge clk_50mhz);

        // Table vectors, bytes back to back
        foreach (v[i]) begin
            q = {};
            for (int k = 0; k < v[i].len; k++) q.push_back(v[i].bytes[(v[i].len - 1 - k) * 8 +: 8]);
            d0 = ndone; e0 = nerr;
            send(q, 0);
            chk($sformatf("vec%0d_done", i), done, v[i].exp_done);
            chk($sformatf("vec%0d_error", i), error, v[i].exp_err);
            chk($sformatf("vec%0d_busy", i), busy, 0);
            chk($sformatf("vec%0d_m", i), m, v[i].exp_m);
            chk($sformatf("vec%0d_n", i), n, v[i].exp_n);
            chk($sformatf("vec%0d_sol", i), solution, v[i].exp_sol);
            @(negedge clk_50mhz);
            chk($sformatf("vec%0d_pulse_end", i), {done, error}, 2'b00);
            chk($sformatf("vec%0d_ndone", i), ndone - d0, v[i].exp_done);
            chk($sformatf("vec%0d_nerr", i), nerr - e0, v[i].exp_ne);
        end

        // Randomized frames against the reference decoder
        rm_sol = v[10].exp_sol; rm_m = v[10].exp_m; rm_n = v[10].exp_n;
        for (int t = 0; t < 60; t++) begin
            int mm, nn, dd, gap;
            logic [7:0] x, b;
            q = {};
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: q.push_back({4'd0, 4'($urandom_range(0, 15))});
                    1: q.push_back({4'($urandom_range(12, 15)), 4'($urandom_range(0, 15))});
                    2: q.push_back({4'($urandom_range(1, 11)), 4'd0});
                    default: q.push_back({4'($urandom_range(1, 11)), 4'($urandom_range(12, 15))});
                endcase
            end else begin
                mm = $urandom_range(1, 11);
                nn = $urandom_range(1, 11);
                dd = (mm * nn + 7) / 8;
                x = {4'(mm), 4'(nn)};
                q.push_back(x);
                for (int k = 0; k < dd; k++) begin
                    b = 8'($urandom);
                    q.push_back(b);
                    x ^= b;
                end
                if (CK) begin
                    if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
                    q.push_back(x);
                end
            end
            gap = $urandom_range(0, 2);
            ref_frame(q);
            d0 = ndone; e0 = nerr;
            send(q, gap);
            chk($sformatf("rnd%0d_done", t), done, rm_done);
            chk($sformatf("rnd%0d_error", t), error, rm_err);
            chk($sformatf("rnd%0d_m", t), m, rm_m);
            chk($sformatf("rnd%0d_n", t), n, rm_n);
            chk($sformatf("rnd%0d_sol", t), solution, rm_sol);
            @(negedge clk_50mhz);
            chk($sformatf("rnd%0d_counts", t), {32'(ndone - d0), 32'(nerr - e0)},
                {32'(rm_done), 32'(rm_err)});
        end

        // Timeout: header then silence
        q = {8'h23};
        e0 = nerr;
        send(q, 0);
        chk("tmo_busy", busy, 1);
        cyc = 0;
        while (!error && cyc < 3 * TMO) begin
            @(negedge clk_50mhz);
            cyc++;
        end
        chk("tmo_cycles", cyc, TMO);
        chk("tmo_busy_after", busy, 0);
        @(negedge clk_50mhz);
        chk("tmo_nerr", nerr - e0, 1);
        q = {};
        for (int k = 0; k < v[0].len; k++) q.push_back(v[0].bytes[(v[0].len - 1 - k) * 8 +: 8]);
        send(q, 0);
        chk("tmo_next_done", done, 1);
        chk("tmo_next_sol", solution, 121'h2D);

        // Reset mid-frame of an 11x11 frame, byte in reset cycle discarded
        q = {8'hBB, 8'hFF};
        send(q, 0);
        chk("rstmid_busy", busy, 1);
        d0 = ndone; e0 = nerr;
        rst = 1'b1; valid_in = 1'b1; byte_in = 8'hFF;
        @(negedge clk_50mhz);
        rst = 1'b0; valid_in = 1'b0; byte_in = 8'h00;
        chk("rstmid_outputs", {solution, m, n, busy, done, error}, 0);
        repeat (3) @(negedge clk_50mhz);
        chk("rstmid_no_pulse", {32'(ndone - d0), 32'(nerr - e0)}, 0);
        chk("rstmid_idle", busy, 0);
        q = {};
        for (int k = 0; k < v[0].len; k++) q.push_back(v[0].bytes[(v[0].len - 1 - k) * 8 +: 8]);
        send(q, 0);
        chk("rstmid_next_done", done, 1);
        chk("rstmid_next_sol", solution, 121'h2D);
        chk("rstmid_next_mn", {m, n}, 8'h23);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/solution_unpacker.md
# solution_unpacker

Byte-stream reader for the solved-board frame that the assembler writes toward the UART transmitter. It consumes bytes from a `uart_rx`-style valid/data strobe and rebuilds the m×n solution bitmap plus its dimensions. It pulses `done` when a frame is complete, or `error` when a frame is malformed. It is used on the loopback and self-check path (tx looped to a second receiver) and as the reference decoder in the board-level bench.

## Interface
- `MAX_ROWS`, 11, upper bound on m.
- `MAX_COLS`, 11, upper bound on n.
- `TIMEOUT_CYCLES`, 50_000_000, idle cycles allowed between bytes inside a frame (1 s at 50 MHz).
- `clk_50mhz`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `valid_in`  in  1  single-cycle strobe; `byte_in` is valid this cycle.
- `byte_in`  in  8  received byte.
- `solution`  out  MAX_ROWS*MAX_COLS  bitmap; cell (r,c) is at bit r*n+c.
- `m`  out  4  row count from the header.
- `n`  out  4  column count from the header.
- `busy`  out  1  high while a frame is in progress.
- `done`  out  1  one-cycle pulse; frame complete and accepted.
- `error`  out  1  one-cycle pulse; frame rejected.

## Operation
- Frame format:
  - Header byte {m[3:0], n[3:0]}.
  - Then D = ceil(m*n/8) data bytes, row-major cell order, LSB-first: bit k of data byte j is cell 8j+k.
  - Then an optional checksum byte (see Configuration).
- States:
  - IDLE: a valid byte is the header.
    - If 1≤m≤MAX_ROWS and 1≤n≤MAX_COLS: latch m and n, compute D, clear `solution`, byte counter ← 0, go to DATA.
    - Otherwise: pulse `error` and stay in IDLE.
  - DATA: each valid byte writes its 8 bits to `solution[8j +: 8]`, masked to indices < m*n.
    - Padding bits beyond m*n are ignored and never written.
    - On the byte where j = D−1: go to CHECK if checksum is enabled, else pulse `done` and go to IDLE.
  - CHECK: a valid byte is compared with the running XOR of header and all data bytes.
    - Equal: pulse `done`.
    - Unequal: pulse `error`.
    - Either way, go to IDLE.
- Timeout: in DATA or CHECK, if TIMEOUT_CYCLES consecutive cycles pass without `valid_in`, pulse `error` and go to IDLE.
- Arithmetic:
  - m*n is 7 bits (max 121).
  - D is computed as (m*n+7)>>3, max 16; the byte counter is 5 bits.
- Frame results:
  - After `error`, `solution`, `m` and `n` keep their partially written contents. Consumers qualify them with `done` only.
  - After `done`, outputs hold stable until the next valid header is accepted.
- `busy` = state ≠ IDLE.

## Timing
- Reset values: `solution`=0, `m`=0, `n`=0, `busy`=0, `done`=0, `error`=0, state IDLE, timer 0.
- All outputs are registered.
- `done` and `error` assert in the cycle after the terminating `valid_in` and last exactly one cycle.
- The block accepts one byte per cycle; there is no back-pressure and no byte is ever dropped.
- A byte arriving in the same cycle that `done` or `error` is high is already processed in IDLE as a new header.
- The `solution` update for data byte j is visible the cycle after its strobe.
- The timeout counter resets on every `valid_in`. When it reaches TIMEOUT_CYCLES−1 with no strobe, the next edge enters IDLE with `error`=1.
- `rst` mid-frame:
  - Returns to IDLE and clears all outputs on the next edge.
  - Any byte in the reset cycle is discarded.
  - Neither `done` nor `error` is issued for the aborted frame.

## Configuration
- `SOLUTION_CHECKSUM_EN`
  - Defined: the frame ends with an XOR checksum byte, and the CHECK state and XOR accumulator exist. A mismatch yields `error`, not `done`.
  - Undefined: no checksum byte and no CHECK state. `done` follows the last data byte directly. The assembler must be built with the same setting.

## Structure
- Shared package `nonogram_pkg` holds:
  - MAX_ROWS, MAX_COLS and derived widths: dimension width 4, cell count 121, max byte count 16.
  - The header field layout.
  - The state enum {IDLE, DATA, CHECK}.
- Sub-module `idle_timer`: a counter with parameter TIMEOUT_CYCLES and ports `clr`, `en`, `expired`. It is reused by the parser for the receive-side timeout.

## Test plan
- 2×3 frame, checksum on: 0x23, 0x2D, 0x0E → `done` one cycle after the last byte; `solution[5:0]`=6'b101101, rest 0; m=2, n=3.
- 11×11 frame: 0xBB, sixteen 0xFF, checksum 0xBB → `solution` all 121 bits 1, `done`=1; padding bits 121..127 do not fault.
- Bad checksum: 0x23, 0x2D, 0x0F → `error` pulse, no `done`. A following valid frame decodes normally.
- Bad header 0xC3 (m=12) or 0x20 (n=0) → immediate `error`, `busy` stays 0. A next byte 0x23 is taken as a header.
- Timeout (TIMEOUT_CYCLES=100 in the bench): 0x23, then silence → `error` exactly 100 cycles after the header strobe, then IDLE.
- `rst` asserted after the header and one data byte of an 11×11 frame → all outputs 0 next cycle, no pulses. A fresh 2×3 frame then gives `done`.
